// File: rtl/spi_command_decoder.sv
// SPI command deframer: builds instruction/address/value commands and drives the SPI tx byte.
// Optional FRAME_TIMEOUT_EN aborts a PAYLOAD frame after TIMEOUT_CYCLES idle cycles.
package titan_comms_pkg;
  localparam logic [7:0] OP_WRITE              = 8'h01;
  localparam logic [7:0] OP_READ               = 8'h02;
  localparam logic [7:0] OP_BIND_INTERRUPT     = 8'h03;
  localparam logic [7:0] OP_BIND_READ_ADDRESS  = 8'h04;
  localparam logic [7:0] OP_BIND_WRITE_ADDRESS = 8'h05;
  localparam logic [7:0] OP_TRANSFER           = 8'h06;
  localparam logic [7:0] OP_REPEAT             = 8'h07;
  localparam logic [7:0] OP_STREAM             = 8'h08;
endpackage

module spi_command_decoder
  import titan_comms_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 24,
  parameter int VALUE_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     spi_rx_valid_i,
  input  logic [7:0]               spi_rx_byte_i,
  input  logic [VALUE_WIDTH-1:0]   result_i,
  input  logic [VALUE_WIDTH-1:0]   stream_i,
  output logic [7:0]               instruction_o,
  output logic [ADDRESS_WIDTH-1:0] address_o,
  output logic [VALUE_WIDTH-1:0]   value_o,
  output logic                     cmd_valid_o,
  output logic [7:0]               spi_tx_byte_o,
  output logic                     busy_o,
  output logic                     error_o
);

  localparam int AB = ADDRESS_WIDTH / 8;
  localparam int VB = VALUE_WIDTH / 8;
  localparam int TW = ADDRESS_WIDTH + VALUE_WIDTH;
  localparam int RW = $clog2(AB + VB + 1);
  localparam int PW = (VB > 1) ? $clog2(VB) : 1;
  localparam int SW = $clog2(VB + 1);

  typedef enum logic {
    IDLE,
    PAYLOAD
  } state_e;

  state_e                   state_q;
  logic [7:0]               op_q;
  logic [RW-1:0]            remain_q;
  logic [TW-9:0]            asm_q;
  logic [VALUE_WIDTH-1:0]   ssh_q;
  logic [SW-1:0]            sidx_q;
  logic [VALUE_WIDTH-1:0]   rsh_q;
  logic [PW-1:0]            ptr_q;
  logic [7:0]               instr_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [VALUE_WIDTH-1:0]   value_q;
  logic                     cmd_q;
  logic [7:0]               tx_q;
  logic                     busy_q;
  logic                     err_q;

  function automatic logic [7:0] byte_at(
    input logic [VALUE_WIDTH-1:0] w,
    input int unsigned            idx
  );
    logic [VALUE_WIDTH-1:0] s;
    s = w << (idx * 8);
    return s[VALUE_WIDTH-1 -: 8];
  endfunction

  logic [RW-1:0] rx_len;
  logic          rx_multi;
  logic          rx_known;

  always_comb begin
    rx_len   = '0;
    rx_multi = 1'b0;
    rx_known = 1'b1;
    unique case (1'b1)
      (spi_rx_byte_i == OP_WRITE): begin
        rx_len   = RW'(AB + VB);
        rx_multi = 1'b1;
      end
      (spi_rx_byte_i == OP_READ),
      (spi_rx_byte_i == OP_BIND_INTERRUPT),
      (spi_rx_byte_i == OP_BIND_READ_ADDRESS),
      (spi_rx_byte_i == OP_BIND_WRITE_ADDRESS): begin
        rx_len   = RW'(AB);
        rx_multi = 1'b1;
      end
      (spi_rx_byte_i == OP_STREAM): begin
        rx_len   = RW'(VB);
        rx_multi = 1'b1;
      end
      (spi_rx_byte_i == OP_TRANSFER),
      (spi_rx_byte_i == OP_REPEAT): begin
        rx_len = '0;
      end
      default: rx_known = 1'b0;
    endcase
  end

  logic [TW-1:0]          asm_d;
  logic [VALUE_WIDTH-1:0] xfer_word;
  logic [PW-1:0]          ptr_d;
  logic [7:0]             stream_d;

  assign asm_d     = {asm_q, spi_rx_byte_i};
  assign xfer_word = (ptr_q == '0) ? result_i : rsh_q;
  assign ptr_d     = (ptr_q == PW'(VB - 1)) ? '0 : ptr_q + 1'b1;
  assign stream_d  = (sidx_q < SW'(VB)) ? byte_at(ssh_q, 32'(sidx_q)) : 8'h00;

`ifdef FRAME_TIMEOUT_EN
  localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMW-1:0] tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= '0;
      remain_q <= '0;
      asm_q    <= '0;
      ssh_q    <= '0;
      sidx_q   <= '0;
      rsh_q    <= '0;
      ptr_q    <= '0;
      instr_q  <= '0;
      addr_q   <= '0;
      value_q  <= '0;
      cmd_q    <= 1'b0;
      tx_q     <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      cmd_q <= 1'b0;
      err_q <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      // a byte on the expiry cycle wins over the timeout
      if (state_q == PAYLOAD && !spi_rx_valid_i) begin
        if (tmo_q == TMW'(TIMEOUT_CYCLES - 1)) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          err_q   <= 1'b1;
          tx_q    <= 8'h00;
          tmo_q   <= '0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end
`endif
      if (spi_rx_valid_i) begin
        if (state_q == IDLE) begin
          if (rx_multi) begin
            op_q     <= spi_rx_byte_i;
            remain_q <= rx_len;
            asm_q    <= '0;
            state_q  <= PAYLOAD;
            busy_q   <= 1'b1;
`ifdef FRAME_TIMEOUT_EN
            tmo_q    <= '0;
`endif
          end
          if (spi_rx_byte_i == OP_STREAM) begin
            ssh_q  <= stream_i;
            tx_q   <= byte_at(stream_i, 0);
            sidx_q <= SW'(1);
          end
          if (spi_rx_byte_i == OP_TRANSFER) begin
            if (ptr_q == '0) rsh_q <= result_i;
            tx_q  <= byte_at(xfer_word, 32'(ptr_q));
            ptr_q <= ptr_d;
          end
          if (spi_rx_byte_i == OP_REPEAT) begin
            ptr_q <= '0;
            tx_q  <= 8'h00;
          end
          if (!rx_known) begin
            err_q <= 1'b1;
            tx_q  <= 8'h00;
          end
        end else begin
          asm_q    <= asm_d[TW-9:0];
          remain_q <= remain_q - 1'b1;
`ifdef FRAME_TIMEOUT_EN
          tmo_q    <= '0;
`endif
          if (op_q == OP_STREAM) begin
            tx_q   <= stream_d;
            sidx_q <= (sidx_q < SW'(VB)) ? sidx_q + 1'b1 : sidx_q;
          end
          if (remain_q == RW'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cmd_q   <= 1'b1;
            instr_q <= op_q;
            unique case (1'b1)
              (op_q == OP_WRITE): begin
                addr_q  <= asm_d[TW-1 -: ADDRESS_WIDTH];
                value_q <= asm_d[VALUE_WIDTH-1:0];
              end
              (op_q == OP_STREAM): begin
                addr_q  <= '0;
                value_q <= asm_d[VALUE_WIDTH-1:0];
              end
              default: begin
                addr_q  <= asm_d[ADDRESS_WIDTH-1:0];
                value_q <= '0;
              end
            endcase
          end
        end
      end
    end
  end

  assign instruction_o = instr_q;
  assign address_o     = addr_q;
  assign value_o       = value_q;
  assign cmd_valid_o   = cmd_q;
  assign spi_tx_byte_o = tx_q;
  assign busy_o        = busy_q;
  assign error_o       = err_q;

endmodule

// File: tb/tb_spi_command_decoder.sv
// Randomised self-checking bench for spi_command_decoder (24-bit address, 32-bit value).
// Timeout scenario is included when FRAME_TIMEOUT_EN is defined.
module tb_spi_command_decoder;

  localparam logic [7:0] C_WRITE  = 8'h01;
  localparam logic [7:0] C_READ   = 8'h02;
  localparam logic [7:0] C_BINT   = 8'h03;
  localparam logic [7:0] C_BRD    = 8'h04;
  localparam logic [7:0] C_BWR    = 8'h05;
  localparam logic [7:0] C_XFER   = 8'h06;
  localparam logic [7:0] C_REPEAT = 8'h07;
  localparam logic [7:0] C_STREAM = 8'h08;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic [31:0] result = 32'h0;
  logic [31:0] stream = 32'h0;
  logic [7:0]  instr;
  logic [23:0] addr;
  logic [31:0] value;
  logic        cmd_valid;
  logic [7:0]  tx;
  logic        busy;
  logic        err;

  int total = 0;
  int bad = 0;
  int ncmd = 0;
  int nerr = 0;

  // transfer model: byte pointer and snapshot
  int          mptr = 0;
  logic [31:0] msnap = 32'h0;

  spi_command_decoder #(
    .ADDRESS_WIDTH (24),
    .VALUE_WIDTH   (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .spi_rx_valid_i(rx_valid),
    .spi_rx_byte_i (rx_byte),
    .result_i      (result),
    .stream_i      (stream),
    .instruction_o (instr),
    .address_o     (addr),
    .value_o       (value),
    .cmd_valid_o   (cmd_valid),
    .spi_tx_byte_o (tx),
    .busy_o        (busy),
    .error_o       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (cmd_valid) ncmd++;
    if (err) nerr++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [7:0] word_byte(input logic [31:0] w, input int i);
    return 8'((w >> (8 * (3 - i))) & 32'hFF);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // model of one TRANSFER: returns the byte the DUT should shift out
  task automatic model_xfer(output logic [7:0] exp);
    if (mptr == 0) msnap = result;
    exp  = word_byte(msnap, mptr);
    mptr = (mptr + 1) % 4;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({instr, addr, value, cmd_valid, tx, busy, err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h/%h/%h/%b/%h/%b/%b want all 0",
               instr, addr, value, cmd_valid, tx, busy, err);
    end
    rst_n = 1'b1;
    mptr = 0;
    @(negedge clk);
  endtask

  task automatic test_write;
    logic [23:0] a;
    logic [31:0] v;
    logic [55:0] frame;
    logic [7:0]  b;
    int c0;
    for (int k = 0; k < 4; k++) begin
      a = (k == 0) ? 24'h123456 : 24'($urandom);
      v = (k == 0) ? 32'hDEADBEEF : $urandom;
      frame = {a, v};
      c0 = ncmd;
      send_byte(C_WRITE);
      total++;
      if (busy !== 1'b1) begin
        bad++; $display("FAIL write_busy_op: got %b want 1", busy);
      end
      for (int i = 0; i < 7; i++) begin
        b = 8'((frame >> (8 * (6 - i))) & 56'hFF);
        send_byte(b);
        total++;
        if (busy !== (i < 6)) begin
          bad++; $display("FAIL write_busy[%0d]: got %b want %b", i, busy, i < 6);
        end
        if (i < 6) begin
          total++;
          if (ncmd != c0) begin
            bad++; $display("FAIL write_early_cmd[%0d]: got %0d want 0", i, ncmd - c0);
          end
        end
      end
      total++;
      if (cmd_valid !== 1'b1 || ncmd - c0 != 1) begin
        bad++; $display("FAIL write_cmd: got %b/%0d want 1/1", cmd_valid, ncmd - c0);
      end
      total++;
      if ({instr, addr, value} !== {C_WRITE, a, v}) begin
        bad++;
        $display("FAIL write_fields: got %h %h %h want %h %h %h", instr, addr, value, C_WRITE, a, v);
      end
    end
    @(negedge clk);
    total++;
    if (cmd_valid !== 1'b0 || {addr, value} !== {a, v}) begin
      bad++; $display("FAIL write_hold: got %b %h %h want 0 %h %h", cmd_valid, addr, value, a, v);
    end
  endtask

  task automatic test_addr_only;
    logic [7:0]  ops[4];
    logic [7:0]  op;
    logic [23:0] a;
    int c0;
    ops[0] = C_READ; ops[1] = C_BINT; ops[2] = C_BRD; ops[3] = C_BWR;
    for (int k = 0; k < 6; k++) begin
      op = (k == 0) ? C_READ : (k == 1) ? C_BWR : ops[$urandom_range(0, 3)];
      a  = (k == 0) ? 24'h00ABCD : (k == 1) ? 24'h000010 : 24'($urandom);
      c0 = ncmd;
      send_byte(op);
      for (int i = 0; i < 3; i++) send_byte(8'((a >> (8 * (2 - i))) & 24'hFF));
      total++;
      if (ncmd - c0 != 1 || busy !== 1'b0) begin
        bad++; $display("FAIL addr_cmd: got %0d/%b want 1/0", ncmd - c0, busy);
      end
      total++;
      if ({instr, addr, value} !== {op, a, 32'h0}) begin
        bad++;
        $display("FAIL addr_fields: got %h %h %h want %h %h 0", instr, addr, value, op, a);
      end
    end
  endtask

  task automatic test_transfer;
    logic [7:0] exp;
    int c0;
    c0 = ncmd;
    result = 32'hCAFEF00D;
    send_byte(C_REPEAT);
    mptr = 0;
    total++;
    if (tx !== 8'h00) begin
      bad++; $display("FAIL repeat_tx: got %h want 00", tx);
    end
    for (int i = 0; i < 5; i++) begin
      send_byte(C_XFER);
      model_xfer(exp);
      total++;
      if (tx !== exp) begin
        bad++; $display("FAIL xfer_fixed[%0d]: got %h want %h", i, tx, exp);
      end
    end
    send_byte(C_REPEAT);
    mptr = 0;
    send_byte(C_XFER);
    model_xfer(exp);
    total++;
    if (tx !== 8'hCA || exp !== 8'hCA) begin
      bad++; $display("FAIL xfer_after_repeat: got %h want CA", tx);
    end
    for (int i = 0; i < 10; i++) begin
      result = $urandom;
      send_byte(C_XFER);
      model_xfer(exp);
      total++;
      if (tx !== exp) begin
        bad++; $display("FAIL xfer_rand[%0d]: got %h want %h", i, tx, exp);
      end
    end
    total++;
    if (ncmd != c0) begin
      bad++; $display("FAIL xfer_no_cmd: got %0d want 0", ncmd - c0);
    end
  endtask

  task automatic test_stream;
    logic [31:0] s;
    logic [31:0] p;
    logic [7:0]  exp;
    int c0;
    for (int k = 0; k < 3; k++) begin
      s = (k == 0) ? 32'h11223344 : $urandom;
      p = (k == 0) ? 32'hAABBCCDD : $urandom;
      stream = s;
      c0 = ncmd;
      send_byte(C_STREAM);
      stream = $urandom;
      total++;
      if (tx !== word_byte(s, 0)) begin
        bad++; $display("FAIL stream_tx0: got %h want %h", tx, word_byte(s, 0));
      end
      for (int i = 0; i < 4; i++) begin
        send_byte(word_byte(p, i));
        exp = (i < 3) ? word_byte(s, i + 1) : 8'h00;
        total++;
        if (tx !== exp) begin
          bad++; $display("FAIL stream_tx[%0d]: got %h want %h", i + 1, tx, exp);
        end
      end
      total++;
      if (ncmd - c0 != 1 || {instr, addr, value} !== {C_STREAM, 24'h0, p}) begin
        bad++;
        $display("FAIL stream_fields: got %0d %h %h %h want 1 %h 0 %h",
                 ncmd - c0, instr, addr, value, C_STREAM, p);
      end
    end
  endtask

  task automatic test_unknown;
    logic [7:0] op;
    logic [7:0] exp;
    int c0, e0;
    for (int k = 0; k < 5; k++) begin
      op = (k == 0) ? 8'hFF : (k == 1) ? 8'h00 : 8'($urandom_range(9, 254));
      result = $urandom | 32'h80000000;
      send_byte(C_XFER);
      model_xfer(exp);
      c0 = ncmd;
      e0 = nerr;
      send_byte(op);
      total++;
      if (err !== 1'b1 || tx !== 8'h00 || busy !== 1'b0) begin
        bad++; $display("FAIL unknown_%h: got err=%b tx=%h busy=%b want 1 00 0", op, err, tx, busy);
      end
      @(negedge clk);
      total++;
      if (nerr - e0 != 1 || ncmd != c0) begin
        bad++; $display("FAIL unknown_pulse_%h: got err=%0d cmd=%0d want 1 0", op, nerr - e0, ncmd - c0);
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] exp;
    int c0;
    send_byte(C_READ);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF);
    send_byte(C_XFER);
    model_xfer(exp);
    c0 = ncmd;
    send_byte(C_WRITE);
    send_byte(8'h12);
    send_byte(8'h34);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({instr, addr, value, cmd_valid, tx, busy, err} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got %h/%h/%h/%b/%h/%b/%b want all 0",
               instr, addr, value, cmd_valid, tx, busy, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
    repeat (2) @(negedge clk);
    total++;
    if (ncmd != c0) begin
      bad++; $display("FAIL midreset_cmd: got %0d want 0", ncmd - c0);
    end
    send_byte(C_READ);
    send_byte(8'h00); send_byte(8'hBE); send_byte(8'hEF);
    total++;
    if (ncmd - c0 != 1 || {instr, addr, value} !== {C_READ, 24'h00BEEF, 32'h0}) begin
      bad++;
      $display("FAIL midreset_read: got %0d %h %h %h want 1 %h 00beef 0", ncmd - c0, instr, addr, value, C_READ);
    end
    result = 32'h5A000000;
    send_byte(C_XFER);
    model_xfer(exp);
    total++;
    if (tx !== exp) begin
      bad++; $display("FAIL midreset_xfer: got %h want %h", tx, exp);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  ops[4];
    logic [7:0]  op;
    logic [7:0]  exp;
    logic [23:0] a;
    logic [31:0] v;
    int kind, c0;
    ops[0] = C_READ; ops[1] = C_BINT; ops[2] = C_BRD; ops[3] = C_BWR;
    for (int k = 0; k < 20; k++) begin
      kind = $urandom_range(0, 3);
      a = 24'($urandom);
      v = $urandom;
      c0 = ncmd;
      if (kind == 0) begin
        send_byte(C_WRITE);
        for (int i = 0; i < 3; i++) send_byte(8'((a >> (8 * (2 - i))) & 24'hFF));
        for (int i = 0; i < 4; i++) send_byte(word_byte(v, i));
        total++;
        if (ncmd - c0 != 1 || {instr, addr, value} !== {C_WRITE, a, v}) begin
          bad++; $display("FAIL b2b_write[%0d]: got %h %h %h want %h %h", k, instr, addr, value, a, v);
        end
      end else if (kind == 1) begin
        op = ops[$urandom_range(0, 3)];
        send_byte(op);
        for (int i = 0; i < 3; i++) send_byte(8'((a >> (8 * (2 - i))) & 24'hFF));
        total++;
        if (ncmd - c0 != 1 || {instr, addr, value} !== {op, a, 32'h0}) begin
          bad++; $display("FAIL b2b_addr[%0d]: got %h %h %h want %h %h 0", k, instr, addr, value, op, a);
        end
      end else if (kind == 2) begin
        result = v;
        send_byte(C_XFER);
        model_xfer(exp);
        total++;
        if (tx !== exp || ncmd != c0) begin
          bad++; $display("FAIL b2b_xfer[%0d]: got %h want %h", k, tx, exp);
        end
      end else begin
        stream = v;
        send_byte(C_STREAM);
        for (int i = 0; i < 4; i++) send_byte(8'((a >> (8 * (i % 3))) & 24'hFF));
        total++;
        if (ncmd - c0 != 1 || tx !== 8'h00 || {instr, addr} !== {C_STREAM, 24'h0}) begin
          bad++; $display("FAIL b2b_stream[%0d]: got %h %h tx=%h want %h 0 00", k, instr, addr, tx, C_STREAM);
        end
      end
    end
  endtask

`ifdef FRAME_TIMEOUT_EN
  task automatic test_timeout;
    int c0, e0;
    c0 = ncmd;
    e0 = nerr;
    send_byte(C_READ);
    send_byte(8'h77);
    repeat (15) @(negedge clk);
    total++;
    if (busy !== 1'b1 || nerr != e0) begin
      bad++; $display("FAIL timeout_early: got busy=%b err=%0d want 1 0", busy, nerr - e0);
    end
    @(negedge clk);
    total++;
    if (err !== 1'b1 || busy !== 1'b0 || tx !== 8'h00) begin
      bad++; $display("FAIL timeout_fire: got err=%b busy=%b tx=%h want 1 0 00", err, busy, tx);
    end
    total++;
    if (ncmd != c0) begin
      bad++; $display("FAIL timeout_cmd: got %0d want 0", ncmd - c0);
    end
    send_byte(C_READ);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    total++;
    if (ncmd - c0 != 1 || {instr, addr, value} !== {C_READ, 24'h010203, 32'h0}) begin
      bad++; $display("FAIL timeout_recover: got %h %h %h want %h 010203 0", instr, addr, value, C_READ);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_addr_only();
    test_transfer();
    test_stream();
    test_unknown();
    test_reset_midframe();
    test_back_to_back();
`ifdef FRAME_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
